dform_exec_unit: RTL and testbench

Parametrised uPower D-form (immediate) execution unit: a 1-read/1-write register file plus a four-state sequencer that accepts one immediate-format instruction per transaction over a valid/ready handshake. It reads the source register, applies the immediate operation and writes the destination register. It replaces the fixed 32x32 single-port register file and the separate field splitter. It sits between the instruction fetch stage and the test/debug harness.

---
 rtl/dform_exec_unit.sv | 151 +++++++++++++++
 tb/tb_dform_exec_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dform_exec_unit.sv
// dform_exec_unit: D-form immediate execution unit.
// 1R/1W register file plus an IDLE/READ/EXEC/WRITE sequencer; one instruction
// every four cycles over a valid/ready handshake, with external preload and
// asynchronous debug read ports.
module dform_exec_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done_valid,
    output logic              done_illegal,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_result
);

    localparam int unsigned NREGS = 2 ** REG_AW;
    // Number of instruction field bits that reach the register address.
    localparam int unsigned FW = (REG_AW < 5) ? REG_AW : 5;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
    typedef enum logic [2:0] {OP_ADDI, OP_ADDIS, OP_ORI, OP_XORI, OP_ANDI, OP_ILL} op_t;

    state_t            state, state_n;
    op_t               op_q;
    logic [31:0]       instr_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] opnd_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic [REG_AW-1:0] fld_a, fld_b;
    logic [DATA_W-1:0] imm_s, imm_z;
    logic [5:0]        opcode;

    assign opcode   = instr_q[31:26];
    assign imm_s    = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign imm_z    = {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    assign dbg_data = regs[dbg_addr];

    // Register-address fields: low bits of A/B, upper address bits zero.
    always_comb begin
        fld_a = '0;
        fld_b = '0;
        for (int unsigned i = 0; i < FW; i++) begin
            fld_a[i] = instr_q[21+i];
            fld_b[i] = instr_q[16+i];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake logic.
    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = !ext_we && !reset;
                if (instr_valid && instr_ready) state_n = S_READ;
            end
            S_READ:  state_n = S_EXEC;
            S_EXEC:  state_n = S_WRITE;
            S_WRITE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Instruction latch, decode/operand fetch, execute and retire reporting.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q      <= '0;
            op_q         <= OP_ILL;
            rd_q         <= '0;
            opnd_q       <= '0;
            result_q     <= '0;
            done_valid   <= 1'b0;
            done_illegal <= 1'b0;
            done_rd      <= '0;
            done_result  <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) instr_q <= instr;
                end
                S_READ: begin
                    case (opcode)
                        6'd14, 6'd15: begin
                            op_q   <= (opcode == 6'd14) ? OP_ADDI : OP_ADDIS;
                            rd_q   <= fld_a;
                            opnd_q <= (fld_b == '0) ? '0 : regs[fld_b];
                        end
                        6'd24, 6'd26, 6'd28: begin
                            op_q   <= (opcode == 6'd24) ? OP_ORI :
                                      (opcode == 6'd26) ? OP_XORI : OP_ANDI;
                            rd_q   <= fld_b;
                            opnd_q <= regs[fld_a];
                        end
                        default: begin
                            op_q   <= OP_ILL;
                            rd_q   <= fld_a;
                            opnd_q <= '0;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADDI:  result_q <= opnd_q + imm_s;
                        OP_ADDIS: result_q <= opnd_q + (imm_s << 16);
                        OP_ORI:   result_q <= opnd_q | imm_z;
                        OP_XORI:  result_q <= opnd_q ^ imm_z;
                        OP_ANDI:  result_q <= opnd_q & imm_z;
                        default:  result_q <= '0;
                    endcase
                end
                S_WRITE: begin
                    done_valid   <= 1'b1;
                    done_illegal <= (op_q == OP_ILL);
                    done_rd      <= rd_q;
                    done_result  <= result_q;
                end
                default: ;
            endcase
        end
    end

    // Register file: preload only in IDLE, retire write only for legal ops.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == S_IDLE && ext_we) begin
            regs[ext_addr] <= ext_wdata;
        end else if (state == S_WRITE && op_q != OP_ILL) begin
            regs[rd_q] <= result_q;
        end
    end

endmodule

// File: tb/tb_dform_exec_unit.sv
// Directed testbench for dform_exec_unit: a 32-bit and a 20-bit instance share
// all stimulus; each output is checked against hand-computed values.
module tb_dform_exec_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        ext_we = 1'b0;
    logic [4:0]  ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [4:0]  dbg_addr = '0;

    logic        instr_ready, done_valid, done_illegal;
    logic [4:0]  done_rd;
    logic [31:0] dbg_data, done_result;

    logic        instr_ready_n, done_valid_n, done_illegal_n;
    logic [4:0]  done_rd_n;
    logic [19:0] dbg_data_n, done_result_n;

    int tests_run = 0;
    int tests_failed = 0;

    dform_exec_unit #(.DATA_W(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done_valid(done_valid), .done_illegal(done_illegal),
        .done_rd(done_rd), .done_result(done_result)
    );

    dform_exec_unit #(.DATA_W(20), .REG_AW(5)) dut_n (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready_n), .instr(instr),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata[19:0]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_n),
        .done_valid(done_valid_n), .done_illegal(done_illegal_n),
        .done_rd(done_rd_n), .done_result(done_result_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int a, input int b, input int imm);
        logic [31:0] w;
        w = '0;
        w[31:26] = op[5:0];
        w[25:21] = a[4:0];
        w[20:16] = b[4:0];
        w[15:0]  = imm[15:0];
        return w;
    endfunction

    task automatic check_reg(input string tag, input int addr, input logic [31:0] exp, input logic [19:0] exp_n);
        dbg_addr = addr[4:0];
        #1;
        check({tag, " w32"}, dbg_data, exp);
        check({tag, " w20"}, dbg_data_n, exp_n);
    endtask

    task automatic preload(input int addr, input logic [31:0] data);
        @(negedge clock);
        ext_we = 1'b1;
        ext_addr = addr[4:0];
        ext_wdata = data;
        @(negedge clock);
        ext_we = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input int exp_rd,
                       input logic [31:0] exp_res, input logic [19:0] exp_res_n, input logic exp_ill);
        int lat;
        int wcnt;
        @(negedge clock);
        instr = ins;
        instr_valid = 1'b1;
        wcnt = 0;
        while (!instr_ready && wcnt < 20) begin
            @(negedge clock);
            wcnt++;
        end
        check({tag, " ready"}, instr_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        lat = 1;
        while (!done_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " done_n"}, done_valid_n, 1'b1);
        check({tag, " illegal"}, done_illegal, exp_ill);
        check({tag, " illegal_n"}, done_illegal_n, exp_ill);
        if (!exp_ill) begin
            check({tag, " rd"}, done_rd, exp_rd);
            check({tag, " result"}, done_result, exp_res);
            check({tag, " result_n"}, done_result_n, exp_res_n);
        end
        @(negedge clock);
        check({tag, " pulse end"}, done_valid, 1'b0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready after reset", instr_ready, 1'b1);
        check("done_valid reset", done_valid, 1'b0);
        check("done_illegal reset", done_illegal, 1'b0);
        check("done_rd reset", done_rd, 0);
        check("done_result reset", done_result, 0);
        @(negedge clock);
        for (int i = 0; i < 32; i++) check_reg($sformatf("reset r%0d", i), i, 32'd0, 20'd0);

        // Basic addi.
        preload(1, 32'd212);
        run("addi", mk(14, 14, 1, 15), 14, 32'd227, 20'd227, 1'b0);
        check_reg("r14", 14, 32'd227, 20'd227);

        // B==0 source, sign extension, addis wrap.
        run("addi b0", mk(14, 3, 0, 16'hFFFF), 3, 32'hFFFF_FFFF, 20'hF_FFFF, 1'b0);
        check_reg("r3", 3, 32'hFFFF_FFFF, 20'hF_FFFF);
        run("addis", mk(15, 4, 3, 1), 4, 32'h0000_FFFF, 20'h0_FFFF, 1'b0);
        check_reg("r4", 4, 32'h0000_FFFF, 20'h0_FFFF);
        run("addis hi", mk(15, 9, 1, 16'h0010), 9, 32'h0010_00D4, 20'h0_00D4, 1'b0);

        // Logical ops with zero-extended immediates.
        preload(5, 32'h0000_F0F0);
        run("andi", mk(28, 5, 6, 16'h00FF), 6, 32'h0000_00F0, 20'h0_00F0, 1'b0);
        run("ori", mk(24, 5, 7, 16'h000F), 7, 32'h0000_F0FF, 20'h0_F0FF, 1'b0);
        run("xori", mk(26, 5, 8, 16'hFFFF), 8, 32'h0000_0F0F, 20'h0_0F0F, 1'b0);
        check_reg("r8", 8, 32'h0000_0F0F, 20'h0_0F0F);

        // r0 is writable, but addi/addis with B==0 still read zero.
        run("ori r0", mk(24, 5, 0, 0), 0, 32'h0000_F0F0, 20'h0_F0F0, 1'b0);
        check_reg("r0", 0, 32'h0000_F0F0, 20'h0_F0F0);
        run("addi b0 r0set", mk(14, 10, 0, 1), 10, 32'd1, 20'd1, 1'b0);

        // Illegal opcode: pulse with illegal flag, no write.
        run("illegal", mk(31, 2, 1, 16'h1234), 0, 32'd0, 20'd0, 1'b1);
        check_reg("illegal r2", 2, 32'd0, 20'd0);
        check_reg("illegal r1", 1, 32'd212, 20'd212);

        // Preload and instruction offered together in IDLE.
        @(negedge clock);
        ext_we = 1'b1;
        ext_addr = 5'd11;
        ext_wdata = 32'h55;
        instr = mk(14, 12, 11, 1);
        instr_valid = 1'b1;
        dbg_addr = 5'd11;
        #1;
        check("ready during preload", instr_ready, 1'b0);
        check("dbg old during write", dbg_data, 32'd0);
        @(negedge clock);
        ext_we = 1'b0;
        #1;
        check("ready after preload", instr_ready, 1'b1);
        check("preload r11", dbg_data, 32'h55);
        instr_valid = 1'b0;
        run("addi after preload", mk(14, 12, 11, 1), 12, 32'h56, 20'h56, 1'b0);

        // Reset during EXEC aborts the instruction.
        @(negedge clock);
        instr = mk(14, 13, 1, 5);
        instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (done_valid || done_valid_n) seen++;
            @(negedge clock);
        end
        check("no done after abort", seen, 0);
        check("idle after abort", instr_ready, 1'b1);
        check("done_result cleared", done_result, 0);
        check_reg("abort r13", 13, 32'd0, 20'd0);
        check_reg("abort r1", 1, 32'd0, 20'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
